skin_bbox: RTL and testbench

Downstream stage of the YCbCr colour converter in the skin-colour segmentation pipeline. It consumes the registered Y/Cb/Cr pixel stream and classifies each pixel as skin or non-skin with fixed chroma windows. It emits a one-bit mask stream and tracks pixel coordinates from frame and line markers. At each frame end it reports the bounding box of all skin pixels to the gesture/tracking logic.

---
 rtl/skin_segm_pkg.sv | 25 ++
 rtl/skin_classify.sv | 35 +++
 rtl/skin_bbox.sv | 161 ++++++++++++++++
 tb/tb_skin_bbox.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skin_segm_pkg.sv
// Shared constants and types for the skin-colour segmentation pipeline.
package skin_segm_pkg;

    localparam int unsigned DEF_IMG_W = 640;
    localparam int unsigned DEF_IMG_H = 480;

    localparam logic [7:0] DEF_Y_MIN  = 8'd16;
    localparam logic [7:0] DEF_CB_MIN = 8'd77;
    localparam logic [7:0] DEF_CB_MAX = 8'd127;
    localparam logic [7:0] DEF_CR_MIN = 8'd133;
    localparam logic [7:0] DEF_CR_MAX = 8'd173;

    // Bounding-box fields are sized for the largest supported image.
    localparam int unsigned BB_XW = $clog2(DEF_IMG_W);
    localparam int unsigned BB_YW = $clog2(DEF_IMG_H);

    typedef struct packed {
        logic             found;
        logic [BB_XW-1:0] x_min;
        logic [BB_XW-1:0] x_max;
        logic [BB_YW-1:0] y_min;
        logic [BB_YW-1:0] y_max;
    } bbox_t;

endpackage

// File: rtl/skin_classify.sv
// Fixed-window YCbCr skin classifier; registered mask plus combinational skin_c.
module skin_classify
    import skin_segm_pkg::*;
#(
    parameter logic [7:0] Y_MIN  = DEF_Y_MIN,
    parameter logic [7:0] CB_MIN = DEF_CB_MIN,
    parameter logic [7:0] CB_MAX = DEF_CB_MAX,
    parameter logic [7:0] CR_MIN = DEF_CR_MIN,
    parameter logic [7:0] CR_MAX = DEF_CR_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] y,
    input  logic [7:0] cb,
    input  logic [7:0] cr,
    output logic       skin_c,
    output logic       mask_valid,
    output logic       mask
);

    assign skin_c = (y >= Y_MIN) && (cb >= CB_MIN) && (cb <= CB_MAX)
                 && (cr >= CR_MIN) && (cr <= CR_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_valid <= 1'b0;
            mask       <= 1'b0;
        end else begin
            mask_valid <= in_valid;
            mask       <= in_valid & skin_c;
        end
    end

endmodule

// File: rtl/skin_bbox.sv
// Skin mask stream plus per-frame skin bounding box.
// Optional SKIN_BBOX_COUNT_EN adds a saturating per-frame skin pixel count.
module skin_bbox
    import skin_segm_pkg::*;
#(
    parameter  int unsigned IMG_W = DEF_IMG_W,
    parameter  int unsigned IMG_H = DEF_IMG_H,
    localparam int unsigned XW    = $clog2(IMG_W),
    localparam int unsigned YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          in_eol,
    input  logic [7:0]    y,
    input  logic [7:0]    cb,
    input  logic [7:0]    cr,
    output logic          mask_valid,
    output logic          mask,
    output logic          bbox_valid,
    output logic          bbox_found,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max
`ifdef SKIN_BBOX_COUNT_EN
    ,
    output logic [XW+YW-1:0] skin_count
`endif
);

    localparam int unsigned CW = XW + YW;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d, px;
    logic [YW-1:0] y_q, y_d, py;
    bbox_t         acc_q, acc_d, res_q, res_d, base, merged;
    logic          bbox_valid_d;
    logic          skin_c;
    logic          accept;
    logic          frame_end;
`ifdef SKIN_BBOX_COUNT_EN
    logic [CW-1:0] cnt_q, cnt_d, cnt_res_q, cnt_res_d, cnt_base, cnt_m;
`endif

    skin_classify u_classify (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .y          (y),
        .cb         (cb),
        .cr         (cr),
        .skin_c     (skin_c),
        .mask_valid (mask_valid),
        .mask       (mask)
    );

    // A sof pixel always sits at (0,0) and starts from empty accumulators.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        acc_d        = acc_q;
        res_d        = res_q;
        bbox_valid_d = 1'b0;
        accept       = in_valid && ((state_q == ACTIVE) || in_sof);
        px           = in_sof ? '0 : x_q;
        py           = in_sof ? '0 : y_q;
        frame_end    = accept && in_eol && (py == YW'(IMG_H - 1));
        base         = in_sof ? '0 : acc_q;
        merged       = base;
`ifdef SKIN_BBOX_COUNT_EN
        cnt_d     = cnt_q;
        cnt_res_d = cnt_res_q;
        cnt_base  = in_sof ? '0 : cnt_q;
        cnt_m     = cnt_base;
        if (skin_c && !(&cnt_base)) cnt_m = cnt_base + 1'b1;
`endif

        if (skin_c) begin
            if (!base.found) begin
                merged.found = 1'b1;
                merged.x_min = BB_XW'(px);
                merged.x_max = BB_XW'(px);
                merged.y_min = BB_YW'(py);
                merged.y_max = BB_YW'(py);
            end else begin
                if (BB_XW'(px) < base.x_min) merged.x_min = BB_XW'(px);
                if (BB_XW'(px) > base.x_max) merged.x_max = BB_XW'(px);
                if (BB_YW'(py) < base.y_min) merged.y_min = BB_YW'(py);
                if (BB_YW'(py) > base.y_max) merged.y_max = BB_YW'(py);
            end
        end

        if (accept) begin
            state_d = ACTIVE;
            acc_d   = merged;
`ifdef SKIN_BBOX_COUNT_EN
            cnt_d = cnt_m;
`endif
            if (in_eol) begin
                x_d = '0;
                y_d = (py == YW'(IMG_H - 1)) ? py : py + 1'b1;
            end else begin
                x_d = (px == XW'(IMG_W - 1)) ? px : px + 1'b1;
                y_d = py;
            end
            if (frame_end) begin
                state_d      = IDLE;
                x_d          = '0;
                y_d          = '0;
                acc_d        = '0;
                res_d        = merged;
                bbox_valid_d = 1'b1;
`ifdef SKIN_BBOX_COUNT_EN
                cnt_d     = '0;
                cnt_res_d = cnt_m;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            bbox_valid <= 1'b0;
`ifdef SKIN_BBOX_COUNT_EN
            cnt_q     <= '0;
            cnt_res_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            bbox_valid <= bbox_valid_d;
`ifdef SKIN_BBOX_COUNT_EN
            cnt_q     <= cnt_d;
            cnt_res_q <= cnt_res_d;
`endif
        end
    end

    assign bbox_found = res_q.found;
    assign x_min      = XW'(res_q.x_min);
    assign x_max      = XW'(res_q.x_max);
    assign y_min      = YW'(res_q.y_min);
    assign y_max      = YW'(res_q.y_max);
`ifdef SKIN_BBOX_COUNT_EN
    assign skin_count = cnt_res_q;
`endif

endmodule

// File: tb/tb_skin_bbox.sv
// Randomized bench for skin_bbox on a reduced 64x48 image with a map-based reference.
module tb_skin_bbox;

    localparam int W  = 64;
    localparam int H  = 48;
    localparam int XW = 6;
    localparam int YW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_eol = 1'b0;
    logic [7:0]    y = '0, cb = '0, cr = '0;
    logic          mask_valid, mask, bbox_valid, bbox_found;
    logic [XW-1:0] x_min, x_max;
    logic [YW-1:0] y_min, y_max;
`ifdef SKIN_BBOX_COUNT_EN
    logic [XW+YW-1:0] skin_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    bit skin_map [H][W];
    bit black_mode = 0;
    int exp_found, exp_x0, exp_x1, exp_y0, exp_y1, exp_cnt;
    int rep_found = 0, rep_x0 = 0, rep_x1 = 0, rep_y0 = 0, rep_y1 = 0, rep_cnt = 0;

    skin_bbox #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_eol     (in_eol),
        .y          (y),
        .cb         (cb),
        .cr         (cr),
        .mask_valid (mask_valid),
        .mask       (mask),
        .bbox_valid (bbox_valid),
        .bbox_found (bbox_found),
        .x_min      (x_min),
        .x_max      (x_max),
        .y_min      (y_min),
        .y_max      (y_max)
`ifdef SKIN_BBOX_COUNT_EN
        ,
        .skin_count (skin_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit is_skin(input logic [7:0] yy, input logic [7:0] cbb, input logic [7:0] crr);
        return (yy >= 16) && (cbb >= 77) && (cbb <= 127) && (crr >= 133) && (crr <= 173);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_bbox_outputs();
        chk("bbox_found", 32'(bbox_found), 32'(rep_found));
        chk("x_min", 32'(x_min), 32'(rep_x0));
        chk("x_max", 32'(x_max), 32'(rep_x1));
        chk("y_min", 32'(y_min), 32'(rep_y0));
        chk("y_max", 32'(y_max), 32'(rep_y1));
`ifdef SKIN_BBOX_COUNT_EN
        chk("skin_count", 32'(skin_count), 32'(rep_cnt));
`endif
    endtask

    // One clock of stimulus followed by checks of that pixel's results.
    task automatic cycle(input logic v, input logic sof, input logic eol,
                         input logic [7:0] yy, input logic [7:0] cbb, input logic [7:0] crr,
                         input bit fe);
        in_valid = v; in_sof = sof; in_eol = eol; y = yy; cb = cbb; cr = crr;
        @(posedge clk);
        #1;
        chk("mask_valid", 32'(mask_valid), 32'(v));
        if (v) chk("mask", 32'(mask), 32'(is_skin(yy, cbb, crr)));
        chk("bbox_valid", 32'(bbox_valid), 32'(fe));
        if (fe) begin
            rep_found = exp_found; rep_x0 = exp_x0; rep_x1 = exp_x1;
            rep_y0 = exp_y0; rep_y1 = exp_y1; rep_cnt = exp_cnt;
        end
        chk_bbox_outputs();
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    endtask

    task automatic gen(input bit want, output logic [7:0] yy, output logic [7:0] cbb, output logic [7:0] crr);
        if (black_mode) begin
            yy = 8'($urandom_range(0, 15)); cbb = 8'($urandom); crr = 8'($urandom);
        end else if (want) begin
            yy = 8'($urandom_range(16, 255)); cbb = 8'($urandom_range(77, 127));
            crr = 8'($urandom_range(133, 173));
        end else begin
            do begin
                yy = 8'($urandom); cbb = 8'($urandom); crr = 8'($urandom);
            end while (is_skin(yy, cbb, crr));
        end
    endtask

    task automatic compute_exp();
        exp_found = 0; exp_x0 = 0; exp_x1 = 0; exp_y0 = 0; exp_y1 = 0; exp_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (skin_map[r][c]) begin
                    if (exp_found == 0) begin
                        exp_found = 1; exp_x0 = c; exp_x1 = c; exp_y0 = r; exp_y1 = r;
                    end else begin
                        if (c < exp_x0) exp_x0 = c;
                        if (c > exp_x1) exp_x1 = c;
                        if (r < exp_y0) exp_y0 = r;
                        if (r > exp_y1) exp_y1 = r;
                    end
                    exp_cnt++;
                end
    endtask

    task automatic clear_map();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                skin_map[r][c] = 0;
    endtask

    task automatic random_map(input int pct);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                skin_map[r][c] = ($urandom % 100) < pct;
    endtask

    // Sends the first nrows rows of the current map, sof on the first pixel.
    task automatic send_rows(input int nrows, input int gap_pct, input bit full);
        logic [7:0] yy, cbb, crr;
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < W; c++) begin
                while (($urandom % 100) < gap_pct)
                    cycle(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
                gen(skin_map[r][c], yy, cbb, crr);
                cycle(1'b1, (r == 0 && c == 0), (c == W - 1), yy, cbb, crr,
                      full && (r == H - 1) && (c == W - 1));
            end
    endtask

    logic [7:0] dy  [8] = '{8'd120, 8'd10,  8'd120, 8'd120, 8'd120, 8'd120, 8'd120, 8'd120};
    logic [7:0] dcb [8] = '{8'd100, 8'd100, 8'd77,  8'd127, 8'd100, 8'd100, 8'd76,  8'd100};
    logic [7:0] dcr [8] = '{8'd150, 8'd150, 8'd150, 8'd150, 8'd133, 8'd173, 8'd150, 8'd174};
    bit         dm  [8] = '{1, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        // Reset state
        #12;
        chk("rst_mask_valid", 32'(mask_valid), 32'd0);
        chk("rst_mask", 32'(mask), 32'd0);
        chk("rst_bbox_valid", 32'(bbox_valid), 32'd0);
        chk_bbox_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Classifier thresholds while idle (no sof, so no frame starts)
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, dy[i], dcb[i], dcr[i], 1'b0);
            chk("dir_mask", 32'(mask), 32'(dm[i]));
        end

        // Two sparse skin pixels
        clear_map();
        skin_map[7][5] = 1;
        skin_map[40][60] = 1;
        compute_exp();
        send_rows(H, 0, 1);

        // All-black frame, then back-to-back frame with skin only at (0,0)
        black_mode = 1;
        clear_map();
        compute_exp();
        send_rows(H, 0, 1);
        black_mode = 0;
        skin_map[0][0] = 1;
        compute_exp();
        send_rows(H, 0, 1);

        // Abort at line 20, then a full restarted frame
        clear_map();
        skin_map[2][3] = 1;
        skin_map[19][63] = 1;
        send_rows(20, 0, 0);
        clear_map();
        skin_map[25][30] = 1;
        skin_map[30][40] = 1;
        compute_exp();
        send_rows(H, 0, 1);

        // Dense random frame with input gaps
        random_map(30);
        compute_exp();
        send_rows(H, 10, 1);

        // Reset mid-frame with gaps
        random_map(20);
        send_rows(10, 15, 0);
        #2;
        rst_n = 1'b0;
        #1;
        rep_found = 0; rep_x0 = 0; rep_x1 = 0; rep_y0 = 0; rep_y1 = 0; rep_cnt = 0;
        chk("arst_mask_valid", 32'(mask_valid), 32'd0);
        chk("arst_bbox_valid", 32'(bbox_valid), 32'd0);
        chk_bbox_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Pixels without sof after reset must not start a frame
        cycle(1'b1, 1'b0, 1'b0, 8'd120, 8'd100, 8'd150, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'd120, 8'd100, 8'd150, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'd50, 8'd90, 8'd140, 1'b0);
        random_map(5);
        compute_exp();
        send_rows(H, 20, 1);

        // Exactly 1234 skin pixels
        clear_map();
        for (int n = 0; n < 1234; ) begin
            int r, c;
            r = $urandom_range(0, H - 1);
            c = $urandom_range(0, W - 1);
            if (!skin_map[r][c]) begin
                skin_map[r][c] = 1;
                n++;
            end
        end
        compute_exp();
        send_rows(H, 0, 1);

        // Idle tail: report holds
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
